// File: rtl/pad_input_bank_ctrl_if.sv
// Signal bundle between the pad-input bank controller and its environment.
// The master side drives the enable request, pad mask and raw pad levels;
// the slave side (the controller) returns the IO-cell enables, the ready
// status, the filtered levels and the edge pulses.
interface pad_input_bank_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [WIDTH-1:0] pin_mask;
  logic [WIDTH-1:0] pad_i;
  logic [WIDTH-1:0] pad_ie;
  logic             ready;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (
    output enable, pin_mask, pad_i,
    input  pad_ie, ready, value, rise, fall
  );

  modport slave (
    input  enable, pin_mask, pad_i,
    output pad_ie, ready, value, rise, fall
  );
endinterface

// File: rtl/pad_input_bank_ctrl.sv
// Pad-input bank controller.
// Sequences the input-enables of a bank of WIDTH IO cells (IDLE -> SETTLE ->
// ACTIVE), then synchronises and debounces the asynchronous receive outputs,
// reporting filtered levels and single-cycle rise/fall pulses.
// Constraints on the parameters: SYNC_STAGES >= 2,
// SETTLE_CYCLES >= SYNC_STAGES, DEBOUNCE_CYCLES >= 1.
module pad_input_bank_ctrl #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                   clock,
  input logic                   reset_n,
  pad_input_bank_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_nxt;
  logic [CNT_W-1:0] settle_cnt;

  logic [WIDTH-1:0] pad_ie_q;
  logic [WIDTH-1:0] pad_ie_d;
  logic             ready_q;
  logic             ready_d;

  // Synchroniser chain: sync_p[0] samples the pads, the last stage is used.
  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  logic [CNT_W-1:0] deb_cnt [WIDTH];
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Masked bits are forced low so they can never load, debounce or pulse.
  assign s = sync_p[SYNC_STAGES-1] & mask_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; dropping enable always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.enable) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!bus.enable)                    state_nxt = IDLE;
        else if (settle_cnt == SETTLE_LAST) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!bus.enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so pad_ie/ready register in step with state.
  always_comb begin
    mask_nxt = mask_q;
    if (state == IDLE && bus.enable) mask_nxt = bus.pin_mask;
    pad_ie_d = (state_nxt != IDLE) ? mask_nxt : '0;
    ready_d  = (state_nxt == ACTIVE);
  end

  // Control registers: mask capture, settle counter, pad enables, ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      settle_cnt <= '0;
      pad_ie_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      mask_q   <= mask_nxt;
      pad_ie_q <= pad_ie_d;
      ready_q  <= ready_d;
      if (state == SETTLE && state_nxt == SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end else begin
        settle_cnt <= '0;
      end
    end
  end

  // Synchroniser: runs while the cells are enabled, held cleared in IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else if (state == IDLE) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= bus.pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  // Debounce filter: load on ACTIVE entry, then require DEBOUNCE_CYCLES
  // consecutive differing samples before a bit changes and pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int k = 0; k < WIDTH; k++) deb_cnt[k] <= '0;
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      if (state == SETTLE && state_nxt == ACTIVE) begin
        value_q <= s;
        for (int k = 0; k < WIDTH; k++) deb_cnt[k] <= '0;
      end else if (state == ACTIVE && state_nxt == ACTIVE) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (s[k] == value_q[k]) begin
            deb_cnt[k] <= '0;
          end else if (deb_cnt[k] == DEB_LAST) begin
            value_q[k] <= s[k];
            rise_q[k]  <= s[k];
            fall_q[k]  <= ~s[k];
            deb_cnt[k] <= '0;
          end else begin
            deb_cnt[k] <= deb_cnt[k] + 1'b1;
          end
        end
      end else begin
        // IDLE, SETTLE, or leaving ACTIVE: value drops to 0 silently.
        value_q <= '0;
        for (int k = 0; k < WIDTH; k++) deb_cnt[k] <= '0;
      end
    end
  end

  assign bus.pad_ie = pad_ie_q;
  assign bus.ready  = ready_q;
  assign bus.value  = value_q;
  assign bus.rise   = rise_q;
  assign bus.fall   = fall_q;

endmodule

// File: tb/tb_pad_input_bank_ctrl.sv
// Scoreboard bench for pad_input_bank_ctrl. The stimulus process pushes the
// expected output snapshot (with the cycle it must appear in) for every
// output event it provokes; the monitor pops one entry each time the DUT
// outputs change or pulse, and compares.
module tb_pad_input_bank_ctrl;

  localparam int W = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  pad_input_bank_ctrl_if #(.WIDTH(W)) bus ();

  pad_input_bank_ctrl #(
    .WIDTH(W),
    .SYNC_STAGES(2),
    .SETTLE_CYCLES(16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [W-1:0] pad_ie;
    logic         ready;
    logic [W-1:0] value;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } snap_t;

  snap_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic expect_ev(input int c, input logic [W-1:0] ie, input logic rdy,
                           input logic [W-1:0] v, input logic [W-1:0] r,
                           input logic [W-1:0] f);
    snap_t e;
    e.cyc = c; e.pad_ie = ie; e.ready = rdy; e.value = v; e.rise = r; e.fall = f;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: an event is any change of pad_ie/ready/value or any pulse.
  snap_t prev = '0;
  always @(negedge clock) begin
    snap_t now;
    snap_t e;
    now.cyc = cyc; now.pad_ie = bus.pad_ie; now.ready = bus.ready;
    now.value = bus.value; now.rise = bus.rise; now.fall = bus.fall;
    if (now.pad_ie != prev.pad_ie || now.ready != prev.ready ||
        now.value != prev.value || now.rise != '0 || now.fall != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d pad_ie=%h ready=%b value=%h rise=%h fall=%h expected=none",
                 now.cyc, now.pad_ie, now.ready, now.value, now.rise, now.fall);
      end else begin
        e = exp_q.pop_front();
        if (e != now) begin
          errors++;
          $display("FAIL event got cyc=%0d pad_ie=%h ready=%b value=%h rise=%h fall=%h expected cyc=%0d pad_ie=%h ready=%b value=%h rise=%h fall=%h",
                   now.cyc, now.pad_ie, now.ready, now.value, now.rise, now.fall,
                   e.cyc, e.pad_ie, e.ready, e.value, e.rise, e.fall);
        end
      end
    end
    prev = now;
  end

  initial begin
    int c;
    bus.enable   = 1'b0;
    bus.pin_mask = '0;
    bus.pad_i    = '0;
    reset_n      = 1'b0;
    tick(3);
    check("reset_state", {bus.pad_ie, bus.ready, bus.value, bus.rise, bus.fall}, 64'h0);
    reset_n = 1'b1;
    tick(2);

    // Enable with mask 0x0F, then async reset mid-ACTIVE.
    c = cyc;
    bus.enable = 1'b1; bus.pin_mask = 8'h0F; bus.pad_i = 8'h05;
    expect_ev(c + 1,  8'h0F, 1'b0, 8'h00, 8'h00, 8'h00);
    expect_ev(c + 17, 8'h0F, 1'b1, 8'h05, 8'h00, 8'h00);
    tick(20);
    c = cyc;
    expect_ev(c, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    reset_n = 1'b0;
    bus.enable = 1'b0;
    #1;
    check("async_reset", {bus.pad_ie, bus.ready, bus.value, bus.rise, bus.fall}, 64'h0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Settle abort after 5 enabled cycles.
    c = cyc;
    bus.enable = 1'b1; bus.pin_mask = 8'hFF; bus.pad_i = 8'h00;
    expect_ev(c + 1, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00);
    tick(5);
    bus.enable = 1'b0;
    expect_ev(c + 6, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    tick(5);

    // Re-enable: full settle again, initial load of 0xA5.
    c = cyc;
    bus.enable = 1'b1; bus.pad_i = 8'hA5;
    expect_ev(c + 1,  8'hFF, 1'b0, 8'h00, 8'h00, 8'h00);
    expect_ev(c + 17, 8'hFF, 1'b1, 8'hA5, 8'h00, 8'h00);
    tick(20);

    // Debounce: bit0 falls then rises, 6 cycles after the pad step.
    c = cyc;
    bus.pad_i = 8'hA4;
    expect_ev(c + 6, 8'hFF, 1'b1, 8'hA4, 8'h00, 8'h01);
    tick(10);
    c = cyc;
    bus.pad_i = 8'hA5;
    expect_ev(c + 6, 8'hFF, 1'b1, 8'hA5, 8'h01, 8'h00);
    tick(10);

    // 3-cycle glitch on bit1 is discarded.
    bus.pad_i = 8'hA7;
    tick(3);
    bus.pad_i = 8'hA5;
    tick(10);

    // 4-cycle pulse on bit1 is just long enough to pass.
    c = cyc;
    bus.pad_i = 8'hA7;
    expect_ev(c + 6, 8'hFF, 1'b1, 8'hA7, 8'h02, 8'h00);
    tick(4);
    bus.pad_i = 8'hA5;
    expect_ev(c + 10, 8'hFF, 1'b1, 8'hA5, 8'h00, 8'h02);
    tick(12);

    // All ones, then disable: no fall pulses on the way out.
    c = cyc;
    bus.pad_i = 8'hFF;
    expect_ev(c + 6, 8'hFF, 1'b1, 8'hFF, 8'h5A, 8'h00);
    tick(10);
    c = cyc;
    bus.enable = 1'b0;
    expect_ev(c + 1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    tick(5);

    // Masking: upper nibble never reaches value/rise/fall.
    c = cyc;
    bus.enable = 1'b1; bus.pin_mask = 8'h0F; bus.pad_i = 8'hF0;
    expect_ev(c + 1,  8'h0F, 1'b0, 8'h00, 8'h00, 8'h00);
    expect_ev(c + 17, 8'h0F, 1'b1, 8'h00, 8'h00, 8'h00);
    tick(20);
    bus.pad_i = 8'h00;
    tick(10);
    bus.pad_i = 8'hF0;
    tick(10);
    bus.pin_mask = 8'hFF;
    tick(5);
    check("mask_ignored_while_active", {56'h0, bus.pad_ie}, 64'h0F);
    c = cyc;
    bus.pad_i = 8'hFF;
    expect_ev(c + 6, 8'h0F, 1'b1, 8'h0F, 8'h0F, 8'h00);
    tick(10);
    c = cyc;
    bus.pad_i = 8'h00;
    expect_ev(c + 6, 8'h0F, 1'b1, 8'h00, 8'h00, 8'h0F);
    tick(10);

    check("pending_expected_events", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
